// File: rtl/spi_target_pkg.sv
// Shared types and helpers for the SPI target link and its sub-blocks.
package spi_target_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } link_state_e;

  // Picks the bit that leaves a shifter first for the configured bit order.
  function automatic logic bit_order_sel(input logic lsb_first, input logic msb_bit,
                                         input logic lsb_bit);
    return lsb_first ? lsb_bit : msb_bit;
  endfunction

endpackage

// File: rtl/spi_target_fifo.sv
// Synchronous first-word-fall-through FIFO; head data is presented whenever not empty.
module spi_target_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign empty_o    = (r_level == '0);
  assign full_o     = (r_level == (AW+1)'(DEPTH));
  assign level_o    = r_level;
  assign pop_data_o = empty_o ? '0 : r_mem[r_rd_ptr];

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/spi_target_link.sv
// SPI mode-0 target endpoint: oversampled bus front-end, RX FIFO and one-entry TX holding register.
module spi_target_link
  import spi_target_pkg::*;
#(
  parameter int                    CHAR_LEN  = 8,
  parameter int                    RX_DEPTH  = 4,
  parameter bit                    LSB_FIRST = 1'b0,
  parameter logic [CHAR_LEN-1:0]   TX_IDLE   = '1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        spi_sclk_i,
  input  logic                        spi_ss_ni,
  input  logic                        spi_sd_i,
  output logic                        spi_sd_o,
  output logic                        spi_sd_oe_o,
  output logic [CHAR_LEN-1:0]         rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic [$clog2(RX_DEPTH):0]   rx_level_o,
  input  logic [CHAR_LEN-1:0]         tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic                        overrun_o,
  output logic                        underrun_o,
  output logic                        frame_err_o,
  output link_state_e                 dbg_state_o
);

  localparam int CW = $clog2(CHAR_LEN);

  // Handshakes: a word moves when valid && ready in the same clk_i cycle; valid never waits on ready.
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_sd_sync;
  logic                   r_sclk_hist, r_ss_hist;
  link_state_e            r_state, w_state_nxt;
  logic [CW-1:0]          r_bit_cnt;
  logic [CHAR_LEN-1:0]    r_rx, r_tx, r_hold;
  logic                   r_hold_valid, r_oe;
  logic                   r_overrun, r_underrun, r_frame_err;
  logic                   w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_sd;
  logic                   w_start, w_stop, w_rise, w_fall, w_char_done, w_load, w_shift;
  logic                   w_pop, w_push, w_full, w_empty, w_overrun, w_underrun;
  logic [CHAR_LEN-1:0]    w_rx_next, w_load_word;

  // Synchronisers reset to "low" so a select held low across reset is not taken as a new fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '0;
      r_sd_sync   <= '0;
      r_sclk_hist <= 1'b0;
      r_ss_hist   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_ni};
      r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0], spi_sd_i};
      r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_hist   <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] && !r_sclk_hist;
  assign w_sclk_fall = !r_sclk_sync[SYNC_STAGES-1] && r_sclk_hist;
  assign w_ss_rise   = r_ss_sync[SYNC_STAGES-1] && !r_ss_hist;
  assign w_ss_fall   = !r_ss_sync[SYNC_STAGES-1] && r_ss_hist;
  assign w_sd        = r_sd_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_ss_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_start     = (r_state == IDLE) && w_ss_fall;
  assign w_stop      = (r_state == ACTIVE) && w_ss_rise;
  assign w_rise      = (r_state == ACTIVE) && w_sclk_rise && !w_ss_rise;
  assign w_fall      = (r_state == ACTIVE) && w_sclk_fall && !w_ss_rise;
  assign w_char_done = w_rise && (r_bit_cnt == CW'(CHAR_LEN-1));
  // A fall at bit_cnt==0 is a character boundary: the next word replaces the shifter.
  assign w_load      = w_start || (w_fall && (r_bit_cnt == '0));
  assign w_shift     = w_fall && (r_bit_cnt != '0);
  assign w_load_word = r_hold_valid ? r_hold : TX_IDLE;
  assign w_underrun  = w_load && !r_hold_valid;

  assign w_rx_next = LSB_FIRST ? ((r_rx >> 1) | {w_sd, {(CHAR_LEN-1){1'b0}}})
                               : ((r_rx << 1) | {{(CHAR_LEN-1){1'b0}}, w_sd});

  assign w_pop     = rx_valid_o && rx_ready_i;
  assign w_push    = w_char_done && (!w_full || w_pop);
  assign w_overrun = w_char_done && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bit_cnt    <= '0;
      r_rx         <= '0;
      r_tx         <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_oe         <= 1'b0;
      r_overrun    <= 1'b0;
      r_underrun   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_overrun   <= w_overrun;
      r_underrun  <= w_underrun;
      r_frame_err <= w_stop && (r_bit_cnt != '0);
      if (w_start)     r_oe <= 1'b1;
      else if (w_stop) r_oe <= 1'b0;
      if (w_stop)           r_bit_cnt <= '0;
      else if (w_char_done) r_bit_cnt <= '0;
      else if (w_rise)      r_bit_cnt <= r_bit_cnt + CW'(1);
      if (w_rise) r_rx <= w_rx_next;
      if (w_load)       r_tx <= w_load_word;
      else if (w_shift) r_tx <= LSB_FIRST ? (r_tx >> 1) : (r_tx << 1);
      // A write arriving with a load from an empty register lands after that load.
      if (w_load) r_hold_valid <= 1'b0;
      if (tx_valid_i && !r_hold_valid) begin
        r_hold_valid <= 1'b1;
        r_hold       <= tx_data_i;
      end
    end
  end

  spi_target_fifo #(
    .WIDTH (CHAR_LEN),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_rx_next),
    .pop_i       (w_pop),
    .pop_data_o  (rx_data_o),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (rx_level_o)
  );

  assign rx_valid_o  = !w_empty;
  assign tx_ready_o  = !r_hold_valid;
  assign spi_sd_oe_o = r_oe;
  assign spi_sd_o    = r_oe && bit_order_sel(LSB_FIRST, r_tx[CHAR_LEN-1], r_tx[0]);
  assign overrun_o   = r_overrun;
  assign underrun_o  = r_underrun;
  assign frame_err_o = r_frame_err;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_spi_target_link.sv
// Directed bench: a mode-0 host model (sclk = clk/8) drives an MSB-first and an LSB-first target.
module tb_spi_target_link;
  import spi_target_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic       rx_ready = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic        sd_o0, oe0, rx_valid0, tx_ready0, ovr0, und0, ferr0;
  logic [7:0]  rx_data0;
  logic [2:0]  level0;
  link_state_e st0;
  logic        sd_o1, oe1, rx_valid1, tx_ready1, ovr1, und1, ferr1;
  logic [7:0]  rx_data1;
  logic [2:0]  level1;
  link_state_e st1;

  int n_assert = 0, n_fail = 0;
  int n_ovr = 0, n_und = 0, n_ferr = 0;

  always #5 clk = ~clk;

  spi_target_link dut0 (
    .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk), .spi_ss_ni(ss_n), .spi_sd_i(mosi),
    .spi_sd_o(sd_o0), .spi_sd_oe_o(oe0), .rx_data_o(rx_data0), .rx_valid_o(rx_valid0),
    .rx_ready_i(rx_ready), .rx_level_o(level0), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready0), .overrun_o(ovr0), .underrun_o(und0), .frame_err_o(ferr0),
    .dbg_state_o(st0)
  );

  spi_target_link #(.LSB_FIRST(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk), .spi_ss_ni(ss_n), .spi_sd_i(mosi),
    .spi_sd_o(sd_o1), .spi_sd_oe_o(oe1), .rx_data_o(rx_data1), .rx_valid_o(rx_valid1),
    .rx_ready_i(rx_ready), .rx_level_o(level1), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready1), .overrun_o(ovr1), .underrun_o(und1), .frame_err_o(ferr1),
    .dbg_state_o(st1)
  );

  // Pulse counters for dut0, sampled with pre-edge values at each rising edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (ovr0)  n_ovr  = n_ovr + 1;
      if (und0)  n_und  = n_und + 1;
      if (ferr0) n_ferr = n_ferr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_start();
    ss_n = 1'b0;
    tick(4);
  endtask

  // Select released while sclk is still high, then sclk parks low in IDLE.
  task automatic ss_end();
    ss_n = 1'b1;
    tick(4);
    sclk = 1'b0;
    tick(4);
  endtask

  task automatic send_bit(input logic b, output logic miso);
    sclk = 1'b0;
    mosi = b;
    tick(4);
    miso = sd_o0;
    sclk = 1'b1;
    tick(4);
  endtask

  task automatic send_char(input logic [7:0] d, input int nbits, output logic [7:0] host_rx);
    logic m;
    host_rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      send_bit(d[7-i], m);
      host_rx = {host_rx[6:0], m};
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(rx_data0), 32'(exp));
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] hrx;
    logic       m;
    int         b_ovr, b_und, b_ferr;

    // Reset values while reset is held.
    tick(3);
    chk("rst_sd_o", 32'(sd_o0), 32'd0);
    chk("rst_oe", 32'(oe0), 32'd0);
    chk("rst_valid", 32'(rx_valid0), 32'd0);
    chk("rst_level", 32'(level0), 32'd0);
    chk("rst_data", 32'(rx_data0), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready0), 32'd1);
    chk("rst_state", 32'(st0), 32'(IDLE));
    rst = 1'b0;
    tick(6);

    // Single char 0xA5 in, 0x3C out, MSB first.
    write_tx(8'h3C);
    chk("t1_tx_ready_full", 32'(tx_ready0), 32'd0);
    ss_n = 1'b0;
    tick(2);
    chk("t1_state_idle", 32'(st0), 32'(IDLE));
    tick(1);
    chk("t1_state_active", 32'(st0), 32'(ACTIVE));
    chk("t1_oe", 32'(oe0), 32'd1);
    chk("t1_tx_ready_load", 32'(tx_ready0), 32'd1);
    chk("t1_first_bit", 32'(sd_o0), 32'd0);
    tick(1);
    send_char(8'hA5, 7, hrx);
    sclk = 1'b0;
    mosi = 1'b1;
    tick(4);
    m = sd_o0;
    hrx = {hrx[6:0], m};
    sclk = 1'b1;
    tick(2);
    chk("t1_valid_early", 32'(rx_valid0), 32'd0);
    tick(1);
    chk("t1_valid", 32'(rx_valid0), 32'd1);
    chk("t1_rx_data", 32'(rx_data0), 32'hA5);
    chk("t1_level", 32'(level0), 32'd1);
    tick(1);
    chk("t1_host_rx", 32'(hrx), 32'h3C);
    ss_end();
    chk("t1_oe_off", 32'(oe0), 32'd0);
    chk("t1_sd_o_off", 32'(sd_o0), 32'd0);
    chk("t1_state_end", 32'(st0), 32'(IDLE));
    chk("t1_no_ovr", 32'(n_ovr), 32'd0);
    chk("t1_no_und", 32'(n_und), 32'd0);
    chk("t1_no_ferr", 32'(n_ferr), 32'd0);
    pop_chk("t1_pop", 8'hA5);
    chk("t1_empty", 32'(level0), 32'd0);

    // Holding register never written: TX_IDLE goes out with one underrun at select.
    b_und = n_und;
    ss_start();
    chk("t3_und_at_ss", 32'(n_und - b_und), 32'd1);
    send_char(8'h5A, 8, hrx);
    chk("t3_host_rx", 32'(hrx), 32'hFF);
    chk("t3_und_total", 32'(n_und - b_und), 32'd1);
    ss_end();
    pop_chk("t3_pop", 8'h5A);

    // Five back-to-back chars with no pops: fifth is dropped.
    b_ovr = n_ovr;
    b_und = n_und;
    ss_start();
    for (int k = 1; k <= 5; k++) send_char(8'(k), 8, hrx);
    ss_end();
    chk("t2_level", 32'(level0), 32'd4);
    chk("t2_ovr", 32'(n_ovr - b_ovr), 32'd1);
    chk("t2_und", 32'(n_und - b_und), 32'd5);
    pop_chk("t2_pop1", 8'h01);
    pop_chk("t2_pop2", 8'h02);
    pop_chk("t2_pop3", 8'h03);
    pop_chk("t2_pop4", 8'h04);
    chk("t2_drained", 32'(rx_valid0), 32'd0);

    // Select released after five rises.
    b_ferr = n_ferr;
    ss_start();
    send_char(8'hF0, 5, hrx);
    ss_n = 1'b1;
    tick(2);
    chk("t4_oe_hold", 32'(oe0), 32'd1);
    tick(1);
    chk("t4_oe_off", 32'(oe0), 32'd0);
    chk("t4_sd_o_off", 32'(sd_o0), 32'd0);
    tick(3);
    sclk = 1'b0;
    tick(4);
    chk("t4_ferr", 32'(n_ferr - b_ferr), 32'd1);
    chk("t4_level", 32'(level0), 32'd0);

    // Full FIFO with a pop on the exact completion cycle of the next char.
    b_ovr = n_ovr;
    ss_start();
    send_char(8'h11, 8, hrx);
    send_char(8'h22, 8, hrx);
    send_char(8'h33, 8, hrx);
    send_char(8'h44, 8, hrx);
    send_char(8'h55, 7, hrx);
    chk("t5_full", 32'(level0), 32'd4);
    sclk = 1'b0;
    mosi = 1'b1;
    tick(4);
    sclk = 1'b1;
    tick(2);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("t5_level", 32'(level0), 32'd4);
    chk("t5_head", 32'(rx_data0), 32'h22);
    tick(1);
    ss_end();
    chk("t5_no_ovr", 32'(n_ovr - b_ovr), 32'd0);
    pop_chk("t5_pop1", 8'h22);
    pop_chk("t5_pop2", 8'h33);
    pop_chk("t5_pop3", 8'h44);
    pop_chk("t5_pop4", 8'h55);

    // LSB-first target: bit sequence 1,0,0,0,0,0,0,0.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    ss_start();
    send_char(8'h80, 8, hrx);
    chk("t6_lsb_valid", 32'(rx_valid1), 32'd1);
    chk("t6_lsb_data", 32'(rx_data1), 32'h01);
    chk("t6_msb_data", 32'(rx_data0), 32'h80);
    ss_end();

    // Reset in the middle of a char, then the rest of that frame is ignored.
    b_ferr = n_ferr;
    ss_start();
    send_char(8'hE0, 3, hrx);
    rst = 1'b1;
    tick(2);
    chk("t6_rst_level", 32'(level1), 32'd0);
    chk("t6_rst_state", 32'(st1), 32'(IDLE));
    chk("t6_rst_oe", 32'(oe1), 32'd0);
    rst = 1'b0;
    send_char(8'hFF, 8, hrx);
    chk("t6_ignored_lsb", 32'(level1), 32'd0);
    chk("t6_ignored_msb", 32'(level0), 32'd0);
    chk("t6_ignored_oe", 32'(oe1), 32'd0);
    ss_end();
    chk("t6_no_ferr", 32'(n_ferr - b_ferr), 32'd0);
    ss_start();
    send_char(8'h80, 8, hrx);
    chk("t6_resume_level", 32'(level1), 32'd1);
    chk("t6_resume_lsb", 32'(rx_data1), 32'h01);
    chk("t6_resume_msb", 32'(rx_data0), 32'h80);
    ss_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target_link.md
Name: spi_target_link

Overview:
- SPI target-side endpoint that sits directly downstream of the SPI host on the same bus.
- Consumes the host's sclk/ss/sd outputs and drives the host's sd input.
- Oversamples the bus in the system clock domain, deserialises received characters into an RX FIFO, and serialises words from a one-entry TX holding register.
- Used as an on-chip loopback peer for the host controller and as the serial front-end of peripheral targets.

Parameters:
- CHAR_LEN, 8: bits per character (2..32).
- RX_DEPTH, 4: RX FIFO entries (power of 2, ≥2).
- LSB_FIRST, 0: 1 = shift LSB first, 0 = MSB first.
- TX_IDLE, all-ones: word transmitted when TX holding register is empty (CHAR_LEN bits).

Ports:
- clk_i  in  1  system clock; ≥8× sclk frequency.
- rst_i  in  1  synchronous reset, active-high.
- spi_sclk_i  in  1  serial clock from host (mode 0: CPOL=0, CPHA=0).
- spi_ss_ni  in  1  target select, active-low.
- spi_sd_i  in  1  host-out/target-in data.
- spi_sd_o  out  1  target-out/host-in data.
- spi_sd_oe_o  out  1  output enable for spi_sd_o.
- rx_data_o  out  CHAR_LEN  head of RX FIFO.
- rx_valid_o  out  1  RX FIFO not empty.
- rx_ready_i  in  1  pop when rx_valid_o && rx_ready_i.
- rx_level_o  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- tx_data_i  in  CHAR_LEN  word for next character.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  TX holding register empty; accepted when tx_valid_i && tx_ready_o.
- overrun_o  out  1  1-cycle pulse: received char dropped, FIFO full.
- underrun_o  out  1  1-cycle pulse: TX_IDLE loaded because holding register was empty.
- frame_err_o  out  1  1-cycle pulse: select released mid-character.

Behaviour:
- Reset (rst_i=1 at clk_i edge) values:
  - spi_sd_o=0, spi_sd_oe_o=0, rx_valid_o=0, rx_level_o=0, rx_data_o=0.
  - tx_ready_o=1; all pulses 0.
  - Bit counter 0, FIFO empty, holding register empty.
  - Reset mid-frame abandons the frame with no pulses; the block resumes only after the next ss fall.
- Input path: sclk, ss_n and sd each pass through a 2-flop synchroniser plus one history flop for edge detection.
  - A pin edge is acted on 3 clk_i cycles after it occurs.
  - sd uses the same-depth synchroniser, so data stays aligned to sclk.
- States: IDLE (ss_n high), ACTIVE (ss_n low).
- IDLE→ACTIVE on the synced ss fall:
  - Load the TX shifter from the holding register (holding register becomes empty, so tx_ready_o=1 on the next cycle).
  - If the holding register is empty, load TX_IDLE and pulse underrun_o.
  - spi_sd_oe_o=1, and spi_sd_o is driven with the first bit in the same cycle.
- ACTIVE, synced sclk rise: shift the synced sd into the RX shifter; bit_cnt++.
- When bit_cnt reaches CHAR_LEN: push the character to the FIFO and set bit_cnt=0.
  - If the FIFO is full and there is no same-cycle pop: drop the character and pulse overrun_o.
  - Push and pop in the same cycle while full: both succeed, no overrun, level unchanged.
- ACTIVE, synced sclk fall:
  - If bit_cnt≠0: advance the TX shifter and drive the next bit.
  - If bit_cnt==0 (character boundary): load the next word (holding register or TX_IDLE plus underrun_o) for back-to-back characters.
- ACTIVE→IDLE on the synced ss rise:
  - spi_sd_oe_o=0, spi_sd_o=0.
  - If bit_cnt≠0: discard the partial character and pulse frame_err_o.
  - bit_cnt=0.
- Bit order: LSB_FIRST selects the shift direction for both RX and TX. Received characters are right-aligned in rx_data_o.
- sclk edges while in IDLE are ignored.
- RX FIFO is first-word-fall-through: rx_data_o is valid whenever rx_valid_o=1. A push into an empty FIFO makes rx_valid_o=1 on the next cycle.
- Holding register: a write is accepted while empty. A write in the same cycle as a load from an empty register is accepted after the load; that load uses TX_IDLE.

Decomposition:
- spi_target_pkg:
  - Constant SYNC_STAGES=2.
  - typedef enum {IDLE, ACTIVE} link_state_e.
  - Function bit_order_sel for shift direction.
- Sub-module spi_target_fifo: synchronous FWFT FIFO parameterised by width and depth, with push/pop/full/empty/level. Reusable by other target peripherals.

Test Plan:
- Host sends 0xA5 (mode 0, sclk = clk/8), tx holding = 0x3C, MSB first → rx_data_o=0xA5, rx_valid_o=1 after the 8th rise plus 3 cycles; host receives 0x3C; no pulses.
- Five back-to-back chars 0x01..0x05 in one frame with rx_ready_i=0 and RX_DEPTH=4 → FIFO holds 0x01..0x04, level=4, one overrun_o pulse on the 5th; popping yields 0x01..0x04 in order.
- Frame with tx holding never written → host reads 0xFF, one underrun_o pulse at ss fall.
- ss released after 5 sclk rises → frame_err_o pulses once, rx_level_o stays 0, spi_sd_oe_o=0 three cycles after the ss rise.
- FIFO full and rx_ready_i=1 on the exact cycle the 8th bit completes → no overrun, level stays 4, new char appended at the tail.
- LSB_FIRST=1, host shifts bit sequence 1,0,0,0,0,0,0,0 → rx_data_o=0x01; rst_i asserted mid-char then ss toggled → counters cleared, next frame received correctly.
